// File: rtl/hoplite_nic.sv
// -----------------------------------------------------------------------------
// hoplite_nic
//
// Network interface between a PicoRV32 tile's memory-mapped network ports and
// its Hoplite router.
//
// Transmit side: the core writes destination coordinates, payload words and a
// packet-complete strobe. Each payload word is first held in a one-flit
// staging register, so the "last" bit can still be set by a later complete
// strobe. The staged flit moves into the TX FIFO either when the next word
// arrives or once the stage has been closed. The TX FIFO feeds the router
// injection port.
//
// Receive side: flits ejected by the router go into the RX FIFO. The core
// sees them through the message-input read interface. A counter of buffered
// last-flits tells the core when at least one whole packet has arrived.
//
// Ports
//   clk, reset            : single rising-edge clock, synchronous active-high reset
//   x/y_coord_out(_valid) : destination coordinate writes from the core
//   message_out(_valid)   : payload word write from the core
//   packet_out_complete   : end-of-packet strobe from the core
//   message_out_ready     : core may write a payload word
//   message_in(_valid)    : RX head payload (0 when empty) and RX non-empty
//   message_in_available  : RX holds at least one last=1 flit
//   message_in_read       : pops the RX head
//   pe_out_data/valid     : TX head flit towards the router
//   pe_out_ready          : router accepts the TX head
//   pe_in_data/valid      : ejected flit from the router (no backpressure)
//   tx_overflow           : sticky, a payload word was dropped
//   rx_overflow           : sticky, an ejected flit was dropped
//
// Flit layout, MSB to LSB: {last, dest_y, dest_x, message[31:0]}
// -----------------------------------------------------------------------------
module hoplite_nic #(
    parameter int COORD_BITS = 1,
    parameter int FIFO_DEPTH = 8,
    localparam int FLIT_BITS = 1 + 2 * COORD_BITS + 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COORD_BITS-1:0] x_coord_out,
    input  logic                  x_coord_out_valid,
    input  logic [COORD_BITS-1:0] y_coord_out,
    input  logic                  y_coord_out_valid,
    input  logic [31:0]           message_out,
    input  logic                  message_out_valid,
    input  logic                  packet_out_complete,
    output logic                  message_out_ready,
    output logic [31:0]           message_in,
    output logic                  message_in_valid,
    output logic                  message_in_available,
    input  logic                  message_in_read,
    output logic [FLIT_BITS-1:0]  pe_out_data,
    output logic                  pe_out_valid,
    input  logic                  pe_out_ready,
    input  logic [FLIT_BITS-1:0]  pe_in_data,
    input  logic                  pe_in_valid,
    output logic                  tx_overflow,
    output logic                  rx_overflow
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int STG_BITS = FLIT_BITS - 1;

    localparam logic [CNT_BITS-1:0] DEPTH_C  = CNT_BITS'(FIFO_DEPTH);
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [PTR_BITS-1:0] PTR_ZERO = {PTR_BITS{1'b0}};
    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

    // Staging register occupancy: EMPTY, HELD (last=0, may still grow the
    // packet) or CLOSED (last=1, waiting only for TX FIFO space).
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HELD   = 2'd1,
        ST_CLOSED = 2'd2
    } stg_state_e;

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    logic [COORD_BITS-1:0] dest_x_r;
    logic [COORD_BITS-1:0] dest_y_r;
    logic [COORD_BITS-1:0] dest_x_s;
    logic [COORD_BITS-1:0] dest_y_s;

    stg_state_e            stg_state_r;
    stg_state_e            stg_state_next_s;
    logic                  stg_valid_s;
    logic                  stg_last_s;
    logic [STG_BITS-1:0]   stg_flit_r;

    logic                  msg_acc_s;
    logic                  msg_drop_s;
    logic                  commit_s;

    logic [FLIT_BITS-1:0]  tx_mem_r [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   tx_wr_ptr_r;
    logic [PTR_BITS-1:0]   tx_rd_ptr_r;
    logic [CNT_BITS-1:0]   tx_count_r;
    logic                  tx_full_s;
    logic                  tx_empty_s;
    logic                  tx_pop_s;

    logic [FLIT_BITS-1:0]  rx_mem_r [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   rx_wr_ptr_r;
    logic [PTR_BITS-1:0]   rx_rd_ptr_r;
    logic [CNT_BITS-1:0]   rx_count_r;
    logic                  rx_full_s;
    logic                  rx_empty_s;
    logic                  rx_push_s;
    logic                  rx_pop_s;
    logic [FLIT_BITS-1:0]  rx_head_s;
    logic                  rx_inc_s;
    logic                  rx_dec_s;
    logic [CNT_BITS-1:0]   rx_packets_r;
    logic                  rx_head_unused_s;

    logic                  tx_overflow_r;
    logic                  rx_overflow_r;

    // ---------------------------------------------------------------------
    // Coordinates: a pulse in the same cycle as a message write takes effect
    // for that message, so the effective coordinate bypasses the register.
    // ---------------------------------------------------------------------
    assign dest_x_s = x_coord_out_valid ? x_coord_out : dest_x_r;
    assign dest_y_s = y_coord_out_valid ? y_coord_out : dest_y_r;

    // Coordinate registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_x_r <= {COORD_BITS{1'b0}};
            dest_y_r <= {COORD_BITS{1'b0}};
        end else begin
            dest_x_r <= dest_x_s;
            dest_y_r <= dest_y_s;
        end
    end

    // ---------------------------------------------------------------------
    // TX control
    // ---------------------------------------------------------------------
    assign tx_full_s         = (tx_count_r == DEPTH_C);
    assign tx_empty_s        = (tx_count_r == CNT_ZERO);
    assign message_out_ready = !stg_valid_s || !tx_full_s;
    assign msg_acc_s         = message_out_valid && message_out_ready;
    assign msg_drop_s        = message_out_valid && !message_out_ready;
    // An accepted message implies FIFO space whenever the stage is occupied,
    // so the full check only matters for a CLOSED stage waiting on its own.
    assign commit_s          = stg_valid_s && !tx_full_s && (msg_acc_s || stg_last_s);
    assign tx_pop_s          = !tx_empty_s && pe_out_ready;

    // Staging FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_state_r <= ST_EMPTY;
        end else begin
            stg_state_r <= stg_state_next_s;
        end
    end

    // Staging FSM: next-state logic. A new message always re-stages, closed
    // at once when the complete strobe arrives with it.
    always_comb begin
        stg_state_next_s = stg_state_r;
        case (stg_state_r)
            ST_EMPTY: begin
                if (msg_acc_s) begin
                    stg_state_next_s = packet_out_complete ? ST_CLOSED : ST_HELD;
                end else begin
                    stg_state_next_s = ST_EMPTY;
                end
            end
            ST_HELD: begin
                if (msg_acc_s) begin
                    stg_state_next_s = packet_out_complete ? ST_CLOSED : ST_HELD;
                end else if (packet_out_complete && !msg_drop_s) begin
                    stg_state_next_s = ST_CLOSED;
                end else begin
                    stg_state_next_s = ST_HELD;
                end
            end
            ST_CLOSED: begin
                if (msg_acc_s) begin
                    stg_state_next_s = packet_out_complete ? ST_CLOSED : ST_HELD;
                end else if (commit_s) begin
                    stg_state_next_s = ST_EMPTY;
                end else begin
                    stg_state_next_s = ST_CLOSED;
                end
            end
            default: begin
                stg_state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Staging FSM: decoded valid/last flags.
    always_comb begin
        stg_valid_s = 1'b0;
        stg_last_s  = 1'b0;
        case (stg_state_r)
            ST_HELD: begin
                stg_valid_s = 1'b1;
                stg_last_s  = 1'b0;
            end
            ST_CLOSED: begin
                stg_valid_s = 1'b1;
                stg_last_s  = 1'b1;
            end
            default: begin
                stg_valid_s = 1'b0;
                stg_last_s  = 1'b0;
            end
        endcase
    end

    // Staged flit body (dest_y, dest_x, payload) loads on every accepted message.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_flit_r <= {STG_BITS{1'b0}};
        end else if (msg_acc_s) begin
            stg_flit_r <= {dest_y_s, dest_x_s, message_out};
        end else begin
            stg_flit_r <= stg_flit_r;
        end
    end

    // TX FIFO storage; not reset, the empty gating on the read mux covers it.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            tx_mem_r[tx_wr_ptr_r] <= {stg_last_s, stg_flit_r};
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr_r <= PTR_ZERO;
            tx_rd_ptr_r <= PTR_ZERO;
            tx_count_r  <= CNT_ZERO;
        end else begin
            if (commit_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            end
            case ({commit_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    assign pe_out_valid = !tx_empty_s;
    assign pe_out_data  = tx_empty_s ? {FLIT_BITS{1'b0}} : tx_mem_r[tx_rd_ptr_r];

    // ---------------------------------------------------------------------
    // RX path
    // ---------------------------------------------------------------------
    assign rx_full_s  = (rx_count_r == DEPTH_C);
    assign rx_empty_s = (rx_count_r == CNT_ZERO);
    assign rx_pop_s   = message_in_read && !rx_empty_s;
    // A same-cycle pop frees the slot the incoming flit needs.
    assign rx_push_s  = pe_in_valid && (!rx_full_s || rx_pop_s);
    assign rx_head_s  = rx_mem_r[rx_rd_ptr_r];
    assign rx_inc_s   = rx_push_s && pe_in_data[FLIT_BITS-1];
    assign rx_dec_s   = rx_pop_s && rx_head_s[FLIT_BITS-1];

    // The core does not see the routing fields of received flits.
    assign rx_head_unused_s = ^rx_head_s[FLIT_BITS-2:32];

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= pe_in_data;
        end
    end

    // RX FIFO pointers, occupancy and buffered-packet count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr_r  <= PTR_ZERO;
            rx_rd_ptr_r  <= PTR_ZERO;
            rx_count_r   <= CNT_ZERO;
            rx_packets_r <= CNT_ZERO;
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase
            case ({rx_inc_s, rx_dec_s})
                2'b10:   rx_packets_r <= rx_packets_r + CNT_ONE;
                2'b01:   rx_packets_r <= rx_packets_r - CNT_ONE;
                default: rx_packets_r <= rx_packets_r;
            endcase
        end
    end

    assign message_in_valid     = !rx_empty_s;
    assign message_in           = rx_empty_s ? 32'h0000_0000 : rx_head_s[31:0];
    assign message_in_available = (rx_packets_r != CNT_ZERO);

    // ---------------------------------------------------------------------
    // Sticky overflow flags
    // ---------------------------------------------------------------------
    // Set on a dropped payload word or a dropped ejected flit; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_overflow_r <= 1'b0;
            rx_overflow_r <= 1'b0;
        end else begin
            tx_overflow_r <= tx_overflow_r | msg_drop_s;
            rx_overflow_r <= rx_overflow_r | (pe_in_valid && !rx_push_s);
        end
    end

    assign tx_overflow = tx_overflow_r;
    assign rx_overflow = rx_overflow_r;

endmodule

// File: tb/tb_hoplite_nic.sv
// -----------------------------------------------------------------------------
// tb_hoplite_nic
//
// Directed bench for hoplite_nic. A queue-based reference model tracks the
// coordinates, the one-flit stage and both FIFOs; a compare process checks
// every DUT output against it each cycle. Directed sequences add literal
// expectations for the test-plan scenarios. Inputs change 2 time units after
// a rising edge; outputs are compared 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_hoplite_nic;

    localparam int CB    = 1;
    localparam int DEPTH = 8;
    localparam int FB    = 1 + 2 * CB + 32;

    logic          clk;
    logic          reset;
    logic [CB-1:0] x_coord_out;
    logic          x_coord_out_valid;
    logic [CB-1:0] y_coord_out;
    logic          y_coord_out_valid;
    logic [31:0]   message_out;
    logic          message_out_valid;
    logic          packet_out_complete;
    logic          message_out_ready;
    logic [31:0]   message_in;
    logic          message_in_valid;
    logic          message_in_available;
    logic          message_in_read;
    logic [FB-1:0] pe_out_data;
    logic          pe_out_valid;
    logic          pe_out_ready;
    logic [FB-1:0] pe_in_data;
    logic          pe_in_valid;
    logic          tx_overflow;
    logic          rx_overflow;

    hoplite_nic #(.COORD_BITS(CB), .FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .x_coord_out          (x_coord_out),
        .x_coord_out_valid    (x_coord_out_valid),
        .y_coord_out          (y_coord_out),
        .y_coord_out_valid    (y_coord_out_valid),
        .message_out          (message_out),
        .message_out_valid    (message_out_valid),
        .packet_out_complete  (packet_out_complete),
        .message_out_ready    (message_out_ready),
        .message_in           (message_in),
        .message_in_valid     (message_in_valid),
        .message_in_available (message_in_available),
        .message_in_read      (message_in_read),
        .pe_out_data          (pe_out_data),
        .pe_out_valid         (pe_out_valid),
        .pe_out_ready         (pe_out_ready),
        .pe_in_data           (pe_in_data),
        .pe_in_valid          (pe_in_valid),
        .tx_overflow          (tx_overflow),
        .rx_overflow          (rx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: plain queues plus the stage contents
    // ---------------------------------------------------------------------
    logic [FB-1:0] txq[$];
    logic [FB-1:0] rxq[$];
    logic          m_sv  = 1'b0;
    logic          m_sl  = 1'b0;
    logic [FB-2:0] m_sd  = '0;
    logic [CB-1:0] m_dx  = '0;
    logic [CB-1:0] m_dy  = '0;
    logic          m_txo = 1'b0;
    logic          m_rxo = 1'b0;

    always begin
        bit            full, rdy, tpop, acc, drop, commit, rpop, rpush;
        logic [CB-1:0] dx, dy;
        int            npk;
        logic [FB-1:0] exp_pod;
        logic [31:0]   exp_min;
        @(posedge clk);
        if (reset) begin
            txq.delete();
            rxq.delete();
            m_sv = 1'b0; m_sl = 1'b0; m_sd = '0;
            m_dx = '0; m_dy = '0; m_txo = 1'b0; m_rxo = 1'b0;
        end else begin
            full   = (txq.size() == DEPTH);
            rdy    = !m_sv || !full;
            tpop   = (txq.size() != 0) && pe_out_ready;
            dx     = x_coord_out_valid ? x_coord_out : m_dx;
            dy     = y_coord_out_valid ? y_coord_out : m_dy;
            acc    = message_out_valid && rdy;
            drop   = message_out_valid && !rdy;
            commit = m_sv && !full && (acc || m_sl);
            if (tpop) void'(txq.pop_front());
            if (commit) txq.push_back({m_sl, m_sd});
            if (drop) begin
                m_txo = 1'b1;
            end else if (acc) begin
                m_sv = 1'b1;
                m_sl = packet_out_complete;
                m_sd = {dy, dx, message_out};
            end else if (commit) begin
                m_sv = 1'b0;
                m_sl = 1'b0;
            end else if (packet_out_complete && m_sv) begin
                m_sl = 1'b1;
            end
            m_dx = dx;
            m_dy = dy;
            rpop  = message_in_read && (rxq.size() != 0);
            rpush = pe_in_valid && ((rxq.size() < DEPTH) || rpop);
            if (pe_in_valid && !rpush) m_rxo = 1'b1;
            if (rpop) void'(rxq.pop_front());
            if (rpush) rxq.push_back(pe_in_data);
        end
        #1;
        npk = 0;
        foreach (rxq[i]) if (rxq[i][FB-1]) npk++;
        exp_pod = (txq.size() != 0) ? txq[0] : '0;
        exp_min = (rxq.size() != 0) ? rxq[0][31:0] : 32'h0;
        chk("message_out_ready", 64'(message_out_ready), 64'(!m_sv || (txq.size() < DEPTH)));
        chk("pe_out_valid", 64'(pe_out_valid), 64'(txq.size() != 0));
        chk("pe_out_data", 64'(pe_out_data), 64'(exp_pod));
        chk("message_in_valid", 64'(message_in_valid), 64'(rxq.size() != 0));
        chk("message_in_available", 64'(message_in_available), 64'(npk != 0));
        chk("message_in", 64'(message_in), 64'(exp_min));
        chk("tx_overflow", 64'(tx_overflow), 64'(m_txo));
        chk("rx_overflow", 64'(rx_overflow), 64'(m_rxo));
    end

    // Log of flits the router actually accepted, and cycles with pe_out_valid high.
    logic [FB-1:0] tx_log[$];
    int            valid_cycles = 0;
    always @(negedge clk) begin
        if (!reset && pe_out_valid === 1'b1) begin
            valid_cycles++;
            if (pe_out_ready) tx_log.push_back(pe_out_data);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_msg(input logic [31:0] m, input logic cmp);
        message_out = m;
        message_out_valid = 1'b1;
        packet_out_complete = cmp;
        tick();
        message_out_valid = 1'b0;
        packet_out_complete = 1'b0;
    endtask

    task automatic complete();
        packet_out_complete = 1'b1;
        tick();
        packet_out_complete = 1'b0;
    endtask

    task automatic inj(input logic [FB-1:0] f, input logic rd);
        pe_in_data = f;
        pe_in_valid = 1'b1;
        message_in_read = rd;
        tick();
        pe_in_valid = 1'b0;
        message_in_read = 1'b0;
    endtask

    task automatic pop();
        message_in_read = 1'b1;
        tick();
        message_in_read = 1'b0;
    endtask

    function automatic logic [FB-1:0] mk(input logic last, input logic [31:0] m);
        return {last, {CB{1'b0}}, {CB{1'b0}}, m};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ready"}, 64'(message_out_ready), 64'd1);
        chk({tag, ".pe_out_valid"}, 64'(pe_out_valid), 64'd0);
        chk({tag, ".pe_out_data"}, 64'(pe_out_data), 64'd0);
        chk({tag, ".message_in_valid"}, 64'(message_in_valid), 64'd0);
        chk({tag, ".available"}, 64'(message_in_available), 64'd0);
        chk({tag, ".message_in"}, 64'(message_in), 64'd0);
        chk({tag, ".tx_overflow"}, 64'(tx_overflow), 64'd0);
        chk({tag, ".rx_overflow"}, 64'(rx_overflow), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Directed sequences
    // ---------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        x_coord_out = '0; x_coord_out_valid = 1'b0;
        y_coord_out = '0; y_coord_out_valid = 1'b0;
        message_out = 32'h0; message_out_valid = 1'b0; packet_out_complete = 1'b0;
        message_in_read = 1'b0; pe_out_ready = 1'b1;
        pe_in_data = '0; pe_in_valid = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Single-flit packet to x=1, y=0.
        tx_log.delete();
        valid_cycles = 0;
        x_coord_out = 1'b1; x_coord_out_valid = 1'b1;
        y_coord_out = 1'b0; y_coord_out_valid = 1'b1;
        tick();
        x_coord_out_valid = 1'b0; y_coord_out_valid = 1'b0;
        wr_msg(32'hDEAD_BEEF, 1'b0);
        complete();
        chk("single.not_yet", 64'(pe_out_valid), 64'd0);
        tick();
        chk("single.valid", 64'(pe_out_valid), 64'd1);
        chk("single.data", 64'(pe_out_data), 64'h5_DEAD_BEEF);
        tick();
        chk("single.gone", 64'(pe_out_valid), 64'd0);
        repeat (3) tick();
        chk("single.count", 64'(tx_log.size()), 64'd1);
        chk("single.valid_cycles", 64'(valid_cycles), 64'd1);

        // Three-word packet.
        tx_log.delete();
        wr_msg(32'h11, 1'b0);
        repeat (3) tick();
        chk("three.none_early", 64'(tx_log.size()), 64'd0);
        wr_msg(32'h22, 1'b0);
        wr_msg(32'h33, 1'b0);
        complete();
        repeat (4) tick();
        chk("three.count", 64'(tx_log.size()), 64'd3);
        if (tx_log.size() == 3) begin
            chk("three.f0", 64'(tx_log[0]), 64'h1_0000_0011);
            chk("three.f1", 64'(tx_log[1]), 64'h1_0000_0022);
            chk("three.f2", 64'(tx_log[2]), 64'h5_0000_0033);
        end

        // TX backpressure: DEPTH+2 writes with the router stalled.
        tx_log.delete();
        pe_out_ready = 1'b0;
        chk("bp.txovf_before", 64'(tx_overflow), 64'd0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            chk("bp.ready_before_write", 64'(message_out_ready), 64'(i <= DEPTH));
            wr_msg(32'h100 + 32'(i), 1'b0);
        end
        chk("bp.ready_low", 64'(message_out_ready), 64'd0);
        chk("bp.txovf_after", 64'(tx_overflow), 64'd1);
        pe_out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("bp.drained", 64'(tx_log.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            if (i < tx_log.size())
                chk("bp.order", 64'(tx_log[i]), 64'h1_0000_0100 + 64'(i));
        end
        complete();
        repeat (4) tick();
        chk("bp.tail_count", 64'(tx_log.size()), 64'(DEPTH + 1));
        if (tx_log.size() == DEPTH + 1)
            chk("bp.tail", 64'(tx_log[DEPTH]), 64'h5_0000_0108);

        // New coordinates, message and complete all in one cycle.
        tx_log.delete();
        x_coord_out = 1'b0; x_coord_out_valid = 1'b1;
        y_coord_out = 1'b1; y_coord_out_valid = 1'b1;
        wr_msg(32'h55, 1'b1);
        x_coord_out_valid = 1'b0; y_coord_out_valid = 1'b0;
        repeat (4) tick();
        chk("same.count", 64'(tx_log.size()), 64'd1);
        if (tx_log.size() == 1)
            chk("same.flit", 64'(tx_log[0]), 64'h6_0000_0055);

        // RX path.
        inj(mk(1'b0, 32'hA), 1'b0);
        chk("rx.valid1", 64'(message_in_valid), 64'd1);
        chk("rx.avail1", 64'(message_in_available), 64'd0);
        chk("rx.data1", 64'(message_in), 64'hA);
        inj(mk(1'b1, 32'hB), 1'b0);
        chk("rx.avail2", 64'(message_in_available), 64'd1);
        chk("rx.head_kept", 64'(message_in), 64'hA);
        pop();
        chk("rx.pop1", 64'(message_in), 64'hB);
        pop();
        chk("rx.empty_valid", 64'(message_in_valid), 64'd0);
        chk("rx.empty_avail", 64'(message_in_available), 64'd0);
        chk("rx.empty_data", 64'(message_in), 64'd0);
        pop();
        chk("rx.pop_empty", 64'(message_in_valid), 64'd0);

        // RX overflow and push with same-cycle pop on a full FIFO.
        for (int i = 0; i < DEPTH; i++) inj(mk(1'b0, 32'h200 + 32'(i)), 1'b0);
        chk("rxo.before", 64'(rx_overflow), 64'd0);
        inj(mk(1'b0, 32'h2FF), 1'b0);
        chk("rxo.set", 64'(rx_overflow), 64'd1);
        chk("rxo.head", 64'(message_in), 64'h200);
        inj(mk(1'b1, 32'h300), 1'b1);
        chk("rxo.swap_head", 64'(message_in), 64'h201);
        chk("rxo.swap_avail", 64'(message_in_available), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("rxo.drain", 64'(message_in), (i < DEPTH - 1) ? 64'h201 + 64'(i) : 64'h300);
            pop();
        end
        chk("rxo.drained", 64'(message_in_valid), 64'd0);

        // Reset with both FIFOs partly full and the stage HELD.
        pe_out_ready = 1'b0;
        wr_msg(32'h71, 1'b0);
        wr_msg(32'h72, 1'b0);
        wr_msg(32'h73, 1'b0);
        inj(mk(1'b0, 32'h81), 1'b0);
        inj(mk(1'b1, 32'h82), 1'b0);
        chk("mid.pre_tx", 64'(pe_out_valid), 64'd1);
        chk("mid.pre_rx", 64'(message_in_available), 64'd1);
        reset = 1'b1;
        tick();
        chk_reset_outputs("mid");
        reset = 1'b0;
        pe_out_ready = 1'b1;
        tx_log.delete();
        complete();
        repeat (5) tick();
        chk("mid.no_stale", 64'(tx_log.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
